// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down-counter with load, pause/resume, terminal-count flag
// and optional auto-reload of the last loaded preset.
module bcd_countdown_timer #(
  parameter int unsigned DIGITS      = 4,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  expired,
  output logic                  load_err
);

  localparam int unsigned W = 4 * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  state_t         state;
  logic [W-1:0]   reload_q;
  logic [W-1:0]   dec_c;
  logic [W-1:0]   san_c;
  logic           bad_c;
  logic           count_zero_c;
  logic           count_one_c;

  // One BCD decrement: zero digits wrap to 9 and pass the borrow upward
  always_comb begin
    logic borrow;
    dec_c  = count;
    borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          dec_c[4*i +: 4] = 4'd9;
        end else begin
          dec_c[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow          = 1'b0;
        end
      end
    end
  end

  // Clamp non-BCD digits of the preset to 9 and flag that it happened
  always_comb begin
    san_c = load_val;
    bad_c = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        san_c[4*i +: 4] = 4'd9;
        bad_c           = 1'b1;
      end
    end
  end

  assign count_zero_c = (count == '0);
  assign count_one_c  = (count == W'(1));

  // Control FSM, count register and pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      reload_q <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        count    <= san_c;
        reload_q <= san_c;
        load_err <= bad_c;
        state    <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (count_zero_c) begin
                state <= ST_EXPIRED;
                done  <= 1'b1;
              end else begin
                state <= ST_RUN;
              end
            end
          end
          ST_RUN: begin
            if (pause) begin
              state <= ST_PAUSED;
            end else if (tick) begin
              if (count_one_c) begin
                done <= 1'b1;
                if (AUTO_RELOAD && (reload_q != '0)) begin
                  count <= reload_q;
                end else begin
                  count <= '0;
                  state <= ST_EXPIRED;
                end
              end else if (!count_zero_c) begin
                count <= dec_c;
              end
            end
          end
          ST_PAUSED: begin
            // A held pause keeps the timer suspended; start alone resumes
            if (start && !pause) begin
              state <= ST_RUN;
            end
          end
          ST_EXPIRED: begin
            count <= '0;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Levels decoded straight from the state register
  assign busy    = (state == ST_RUN);
  assign expired = (state == ST_EXPIRED);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: one instance without and one with auto-reload,
// both compared every cycle against a decimal-arithmetic reference model.
module tb_bcd_countdown_timer;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load, start, pause, tick;
  logic [W-1:0] load_val;

  logic [W-1:0] count0, count1;
  logic         busy0, busy1, done0, done1, expired0, expired1, lerr0, lerr1;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: count held as a plain integer, state as 0=idle 1=run 2=paused 3=expired
  int m_cnt [2];
  int m_rel [2];
  int m_st  [2];
  bit m_done[2];
  bit m_lerr[2];

  always #5 clk = ~clk;

  bcd_countdown_timer #(.DIGITS(DIGITS), .AUTO_RELOAD(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .tick(tick), .count(count0), .busy(busy0), .done(done0),
    .expired(expired0), .load_err(lerr0)
  );

  bcd_countdown_timer #(.DIGITS(DIGITS), .AUTO_RELOAD(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .tick(tick), .count(count1), .busy(busy1), .done(done1),
    .expired(expired1), .load_err(lerr1)
  );

  function automatic int decode_preset(input logic [W-1:0] v, output bit bad);
    int   val = 0;
    int   mul = 1;
    logic [3:0] d;
    bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = v[4*i +: 4];
      if (d > 4'd9) begin
        d   = 4'd9;
        bad = 1'b1;
      end
      val += int'(d) * mul;
      mul *= 10;
    end
    return val;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r = '0;
    int           x = n;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_rel[k] = 0; m_st[k] = 0; m_done[k] = 1'b0; m_lerr[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit bad;
    int v;
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 1'b0;
      m_lerr[k] = 1'b0;
      if (load) begin
        v = decode_preset(load_val, bad);
        m_cnt[k] = v; m_rel[k] = v; m_st[k] = 0; m_lerr[k] = bad;
      end else begin
        case (m_st[k])
          0: if (start) begin
               if (m_cnt[k] == 0) begin m_st[k] = 3; m_done[k] = 1'b1; end
               else m_st[k] = 1;
             end
          1: if (pause) m_st[k] = 2;
             else if (tick) begin
               if (m_cnt[k] == 1) begin
                 m_done[k] = 1'b1;
                 if (k == 1 && m_rel[k] != 0) m_cnt[k] = m_rel[k];
                 else begin m_cnt[k] = 0; m_st[k] = 3; end
               end else begin
                 m_cnt[k] = m_cnt[k] - 1;
               end
             end
          2: if (start && !pause) m_st[k] = 1;
          default: ;
        endcase
      end
    end
  endtask

  task automatic compare_all();
    check("count0",   count0,       to_bcd(m_cnt[0]));
    check("busy0",    W'(busy0),    W'(m_st[0] == 1));
    check("done0",    W'(done0),    W'(m_done[0]));
    check("expired0", W'(expired0), W'(m_st[0] == 3));
    check("lerr0",    W'(lerr0),    W'(m_lerr[0]));
    check("count1",   count1,       to_bcd(m_cnt[1]));
    check("busy1",    W'(busy1),    W'(m_st[1] == 1));
    check("done1",    W'(done1),    W'(m_done[1]));
    check("expired1", W'(expired1), W'(m_st[1] == 3));
    check("lerr1",    W'(lerr1),    W'(m_lerr[1]));
  endtask

  task automatic step(input bit l, input logic [W-1:0] lv, input bit s, input bit p, input bit t);
    load = l; load_val = lv; start = s; pause = p; tick = t;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    model_reset();
    #12;
    compare_all();
    check("rst_count", count0, 16'h0000);
    rst_n = 1'b1;

    // Borrow chain
    step(1, 16'h1000, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 1);
    check("borrow_0999", count0, 16'h0999);
    step(0, '0, 0, 0, 1);
    check("borrow_0998", count0, 16'h0998);
    check("borrow_busy", W'(busy0), W'(1));

    // Terminal count, with and without reload
    step(1, 16'h0002, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    check("term_count",   count0,       16'h0000);
    check("term_done",    W'(done0),    W'(1));
    check("term_expired", W'(expired0), W'(1));
    check("term_reload",  count1,       16'h0002);
    for (int i = 0; i < 5; i++) step(0, '0, 0, 0, 1);
    check("term_hold", count0, 16'h0000);
    check("term_done_low", W'(done0), W'(0));

    // Pause beats tick, resume, then decrement
    step(1, 16'h0050, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 1, 1);
    check("pause_count", count0, 16'h0050);
    check("pause_busy",  W'(busy0), W'(0));
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1);
    check("pause_hold", count0, 16'h0050);
    step(0, '0, 1, 0, 1);
    check("resume_count", count0, 16'h0050);
    step(0, '0, 0, 0, 1);
    check("resume_0049", count0, 16'h0049);

    // Auto-reload period and repeated done
    step(1, 16'h0003, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1);
    check("ar_count", count1, 16'h0003);
    check("ar_done",  W'(done1), W'(1));
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1);
    check("ar_done2", W'(done1), W'(1));
    check("ar_busy",  W'(busy1), W'(1));

    // Preset 0001 with reload pulses done every tick
    step(1, 16'h0001, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1);

    // Invalid digits, then a zero start
    step(1, 16'h00A5, 0, 0, 0);
    check("inv_count", count0, 16'h0095);
    check("inv_err",   W'(lerr0), W'(1));
    step(0, '0, 0, 0, 0);
    step(1, 16'hFFFF, 0, 0, 0);
    check("inv_all9", count0, 16'h9999);
    step(1, 16'h0000, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    check("zero_expired", W'(expired0), W'(1));
    check("zero_done",    W'(done0),    W'(1));
    check("zero_busy",    W'(busy0),    W'(0));

    // Asynchronous reset between clock edges
    step(1, 16'h0012, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 1);
    check("pre_rst_0009", count0, 16'h0009);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(0, '0, 0, 0, 1);
    check("post_rst_idle", count0, 16'h0000);

    // Randomized traffic; start and pause kept exclusive
    for (int n = 0; n < 1500; n++) begin
      automatic bit           l  = ($urandom_range(0, 19) == 0);
      automatic logic [W-1:0] lv = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 3))
                                                              : W'($urandom);
      automatic int           sp = $urandom_range(0, 9);
      automatic bit           t  = ($urandom_range(0, 3) != 0);
      step(l, lv, sp == 0, sp == 1, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
